// File: rtl/icache_fetch_client.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch unit
// and the memory controller's instruction read port.
module icache_fetch_client #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    input  logic        flush,
    output logic [31:0] ins_out,
    output logic        ins_out_valid,
    output logic        ic_flag,
    output logic [31:0] ins_addr,
    input  logic        mc_ic_enable,
    input  logic [31:0] mc_ins,
    input  logic        mc_ins_rdy
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [TAG_BITS-1:0]   tag_d  [LINES];
    logic [31:0]           data_q [LINES];
    logic [31:0]           data_d [LINES];
    logic                  squash_q, squash_d;
    logic [31:0]           ins_out_q, ins_out_d;
    logic                  ins_out_valid_q, ins_out_valid_d;
    logic                  ic_flag_q, ic_flag_d;
    logic [31:0]           ins_addr_q, ins_addr_d;

    logic [INDEX_BITS-1:0] f_idx, m_idx;
    logic [TAG_BITS-1:0]   f_tag, m_tag;
    logic                  hit;
    logic                  unused_low_bits;

    assign f_idx = fetch_addr[INDEX_BITS+1:2];
    assign f_tag = fetch_addr[31:INDEX_BITS+2];
    assign m_idx = ins_addr_q[INDEX_BITS+1:2];
    assign m_tag = ins_addr_q[31:INDEX_BITS+2];
    assign hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign unused_low_bits = ^{fetch_addr[1:0], ins_addr_q[1:0]};

    assign fetch_ready   = (state_q == IDLE);
    assign ins_out       = ins_out_q;
    assign ins_out_valid = ins_out_valid_q;
    assign ic_flag       = ic_flag_q;
    assign ins_addr      = ins_addr_q;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        tag_d           = tag_q;
        data_d          = data_q;
        squash_d        = squash_q;
        ins_out_d       = ins_out_q;
        ins_out_valid_d = 1'b0;
        ic_flag_d       = 1'b0;
        ins_addr_d      = ins_addr_q;

        unique case (state_q)
            IDLE: begin
                if (fetch_valid && !flush) begin
                    if (hit) begin
                        ins_out_d       = data_q[f_idx];
                        ins_out_valid_d = 1'b1;
                    end else begin
                        ins_addr_d = {fetch_addr[31:2], 2'b00};
                        squash_d   = 1'b0;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mc_ic_enable) begin
                    ic_flag_d = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A squashed miss still fills: the address was a legal fetch.
                if (mc_ins_rdy) begin
                    valid_d[m_idx]  = 1'b1;
                    tag_d[m_idx]    = m_tag;
                    data_d[m_idx]   = mc_ins;
                    ins_out_d       = mc_ins;
                    ins_out_valid_d = !(squash_q || flush);
                    squash_d        = 1'b0;
                    state_d         = IDLE;
                end else if (flush) begin
                    squash_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            squash_q        <= 1'b0;
            ins_out_q       <= '0;
            ins_out_valid_q <= 1'b0;
            ic_flag_q       <= 1'b0;
            ins_addr_q      <= '0;
        end else if (rdy) begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            data_q          <= data_d;
            squash_q        <= squash_d;
            ins_out_q       <= ins_out_d;
            ins_out_valid_q <= ins_out_valid_d;
            ic_flag_q       <= ic_flag_d;
            ins_addr_q      <= ins_addr_d;
        end
    end

endmodule

// File: tb/tb_icache_fetch_client.sv
// Bench for icache_fetch_client: directed scenarios followed by random
// traffic, all checked against a word-address level cache model.
module tb_icache_fetch_client;

    logic        clk = 1'b0;
    logic        rst, rdy, fetch_valid, flush, mc_ic_enable, mc_ins_rdy;
    logic [31:0] fetch_addr, mc_ins;
    logic        fetch_ready, ins_out_valid, ic_flag;
    logic [31:0] ins_out, ins_addr;

    always #5 clk = ~clk;

    icache_fetch_client #(.INDEX_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .fetch_valid  (fetch_valid),
        .fetch_addr   (fetch_addr),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .ins_out      (ins_out),
        .ins_out_valid(ins_out_valid),
        .ic_flag      (ic_flag),
        .ins_addr     (ins_addr),
        .mc_ic_enable (mc_ic_enable),
        .mc_ins       (mc_ins),
        .mc_ins_rdy   (mc_ins_rdy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory contents seen through the memory controller.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h40) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Model: each line remembers the full word address it holds.
    bit          line_ok [16];
    logic [29:0] line_wa [16];
    logic [31:0] line_w  [16];
    bit          miss_open, issued, squashed;
    logic [29:0] miss_wa;
    logic        e_flag, e_ov;
    logic [31:0] e_out, e_addr;

    task automatic model_step();
        logic [29:0] wa;
        int          i;
        if (!rst) begin
            for (int k = 0; k < 16; k++) line_ok[k] = 1'b0;
            miss_open = 0; issued = 0; squashed = 0;
            e_flag = 0; e_ov = 0; e_out = 0; e_addr = 0;
            return;
        end
        if (!rdy) return;
        e_flag = 0;
        e_ov   = 0;
        if (!miss_open) begin
            if (fetch_valid && !flush) begin
                wa = fetch_addr[31:2];
                i  = int'(wa % 16);
                if (line_ok[i] && line_wa[i] == wa) begin
                    e_out = line_w[i];
                    e_ov  = 1;
                end else begin
                    miss_open = 1; issued = 0; squashed = 0;
                    miss_wa   = wa;
                    e_addr    = {wa, 2'b00};
                end
            end
        end else if (!issued) begin
            if (flush) miss_open = 0;
            else if (mc_ic_enable) begin
                issued = 1;
                e_flag = 1;
            end
        end else begin
            if (mc_ins_rdy) begin
                i = int'(miss_wa % 16);
                line_ok[i] = 1;
                line_wa[i] = miss_wa;
                line_w[i]  = mc_ins;
                e_out      = mc_ins;
                e_ov       = !squashed;
                miss_open  = 0;
            end else if (flush) begin
                squashed = 1;
            end
        end
    endtask

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("fetch_ready", fetch_ready, !miss_open);
            check("ic_flag", ic_flag, e_flag);
            check("ins_out_valid", ins_out_valid, e_ov);
            check("ins_addr", ins_addr, e_addr);
            if (e_ov) check("ins_out", ins_out, e_out);
        end
    end

    // Memory-controller responder.
    bit          pend = 0;
    int          cnt = 0;
    int          lat = 0;
    logic [31:0] pend_addr = 0;
    bit          drop_on_rst = 0;
    bit          stray_en = 0;
    int          flag_pulses = 0;

    task automatic tick();
        mc_ins_rdy = 1'b0;
        mc_ins     = $urandom;
        if (!rst && drop_on_rst) begin
            pend = 0;
        end else if (ic_flag === 1'b1 && !pend) begin
            pend      = 1;
            cnt       = lat;
            pend_addr = ins_addr;
            flag_pulses++;
        end
        if (pend && rst && rdy) begin
            if (cnt == 0) begin
                mc_ins_rdy = 1'b1;
                mc_ins     = mem(pend_addr);
                pend       = 0;
                flush      = 1'b0;
            end else begin
                cnt--;
            end
        end else if (stray_en && !pend && !(miss_open && issued)
                     && $urandom_range(0, 19) == 0) begin
            mc_ins_rdy = 1'b1;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp,
                              input int max);
        bit got = 0;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (ins_out_valid === 1'b1) got = 1;
        end
        if (got) check(name, ins_out, exp);
        else begin
            tests++;
            fails++;
            $display("FAIL %s: no ins_out_valid within %0d cycles, want %h",
                     name, max, exp);
        end
    endtask

    task automatic fetch_one(input logic [31:0] a);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        tick();
        fetch_valid = 1'b0;
    endtask

    initial begin
        int p;
        bit seen;
        rst = 0; rdy = 1; fetch_valid = 0; fetch_addr = 0; flush = 0;
        mc_ic_enable = 1; mc_ins = 0; mc_ins_rdy = 0;
        lat = 5;
        @(negedge clk);
        tick();
        tick();
        check("rst_fetch_ready", fetch_ready, 1);
        check("rst_ic_flag", ic_flag, 0);
        check("rst_ins_out_valid", ins_out_valid, 0);
        check("rst_ins_out", ins_out, 0);
        check("rst_ins_addr", ins_addr, 0);
        cmp_en = 1;
        rst = 1;

        fetch_one(32'h0);
        check("cold_busy", fetch_ready, 0);
        tick();
        check("cold_flag", ic_flag, 1);
        check("cold_addr", ins_addr, 32'h0);
        wait_valid("cold_data", 32'h13, 20);
        check("cold_pulses", flag_pulses, 1);

        fetch_one(32'h2);
        check("hit_valid", ins_out_valid, 1);
        check("hit_data", ins_out, 32'h13);
        check("hit_noflag", ic_flag, 0);
        check("model_hit", e_out, 32'h13);

        fetch_one(32'h40);
        wait_valid("conflict_data", 32'h0010_0093, 20);
        fetch_one(32'h0);
        check("conflict_refetch_miss", fetch_ready, 0);
        wait_valid("refill_data", 32'h13, 20);
        check("conflict_pulses", flag_pulses, 3);

        mc_ic_enable = 0;
        fetch_one(32'h80);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy_noflag", ic_flag, 0);
        end
        mc_ic_enable = 1;
        tick();
        check("busy_flag", ic_flag, 1);
        p = flag_pulses;
        wait_valid("busy_data", mem(32'h80), 20);
        check("busy_single", flag_pulses, p + 1);

        lat = 6;
        fetch_one(32'hC4);
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ins_out_valid === 1'b1) seen = 1;
        end
        check("flush_squash", seen, 0);
        check("flush_idle", fetch_ready, 1);
        fetch_one(32'hC4);
        check("flush_hit_valid", ins_out_valid, 1);
        check("flush_hit_data", ins_out, mem(32'hC4));
        check("model_flush_fill", e_out, 32'h5A5A_0F0F ^ (32'hC4 * 32'h9E37_79B1));

        lat = 8;
        fetch_one(32'h104);
        tick();
        tick();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_busy", fetch_ready, 0);
            check("freeze_noflag", ic_flag, 0);
            check("freeze_addr", ins_addr, 32'h104);
        end
        rdy = 1;
        wait_valid("freeze_data", mem(32'h104), 20);

        lat = 10;
        fetch_one(32'h144);
        tick();
        tick();
        rst = 0;
        tick();
        rst = 1;
        check("midrst_ready", fetch_ready, 1);
        check("midrst_addr", ins_addr, 0);
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ins_out_valid === 1'b1) seen = 1;
        end
        check("stray_ignored", seen, 0);
        fetch_one(32'h2);
        check("reset_invalidates", fetch_ready, 0);
        wait_valid("reset_refill", 32'h13, 20);

        drop_on_rst = 1;
        stray_en    = 1;
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 199) != 0);
            rdy          = ($urandom_range(0, 9) != 0);
            fetch_valid  = ($urandom_range(0, 9) < 6);
            fetch_addr   = ($urandom_range(0, 1) << 31)
                         | ($urandom_range(0, 3) << 6)
                         | ($urandom_range(0, 15) << 2)
                         | $urandom_range(0, 3);
            flush        = ($urandom_range(0, 11) == 0);
            mc_ic_enable = ($urandom_range(0, 9) < 7);
            lat          = $urandom_range(0, 6);
            tick();
        end

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
